writeback_arbiter: RTL and testbench

Merges the X→W completion streams of several execute units (ALU, multiplier, control-flow unit) into the single writeback port of the W stage. Arbitration is round-robin among the units. The winning message is captured in a one-entry output register, so W sees registered outputs and each unit gets fair access under contention. The block sits between the execute units' W-side val/rdy outputs and the writeback stage's X-side input.

---
 rtl/writeback_arbiter_if.sv | 35 +++
 rtl/writeback_arbiter.sv | 91 +++++++++
 tb/tb_writeback_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Execute-unit to writeback bundle: per-unit X-side val/rdy + fields, single W-side port.
interface writeback_arbiter_if #(
  parameter int p_num_units    = 3,
  parameter int p_seq_num_bits = 5
);
  localparam int src_bits = $clog2(p_num_units);

  logic [p_num_units-1:0]                     x_val;
  logic [p_num_units-1:0]                     x_rdy;
  logic [p_num_units-1:0][31:0]               x_pc;
  logic [p_num_units-1:0][p_seq_num_bits-1:0] x_seq_num;
  logic [p_num_units-1:0][4:0]                x_waddr;
  logic [p_num_units-1:0][31:0]               x_wdata;
  logic [p_num_units-1:0]                     x_wen;

  logic                      w_val;
  logic                      w_rdy;
  logic [31:0]               w_pc;
  logic [p_seq_num_bits-1:0] w_seq_num;
  logic [4:0]                w_waddr;
  logic [31:0]               w_wdata;
  logic                      w_wen;
  logic [src_bits-1:0]       w_src;

  // Environment side: execute units drive X, writeback stage drives w_rdy.
  modport master (
    output x_val, x_pc, x_seq_num, x_waddr, x_wdata, x_wen, w_rdy,
    input  x_rdy, w_val, w_pc, w_seq_num, w_waddr, w_wdata, w_wen, w_src
  );

  modport slave (
    input  x_val, x_pc, x_seq_num, x_waddr, x_wdata, x_wen, w_rdy,
    output x_rdy, w_val, w_pc, w_seq_num, w_waddr, w_wdata, w_wen, w_src
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin merge of execute-unit completions into one registered writeback port.
// Latency 1 cycle; a full, stalled output buffer drops every x_rdy (only w_rdy -> x_rdy is combinational).
module writeback_arbiter #(
  parameter int p_num_units    = 3,
  parameter int p_seq_num_bits = 5
) (
  input logic               clk,
  input logic               rst,
  writeback_arbiter_if.slave bus
);
  localparam int src_bits = $clog2(p_num_units);

  typedef struct packed {
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
    logic [src_bits-1:0]       src;
  } msg_t;

  logic                buf_valid;
  msg_t                buf_q;
  logic [src_bits-1:0] ptr;
  logic [src_bits-1:0] winner;
  logic                any_val;
  logic                can_accept;
  logic                x_hs;
  logic                w_hs;

  function automatic logic [src_bits-1:0] wrap_add(logic [src_bits-1:0] base, int k);
    int s;
    s = int'(base) + k;
    if (s >= p_num_units) s = s - p_num_units;
    return src_bits'(s);
  endfunction

  // Scan from the highest offset down so the last hit is the one nearest ptr.
  always_comb begin
    winner  = '0;
    any_val = 1'b0;
    for (int k = p_num_units - 1; k >= 0; k--) begin
      if (bus.x_val[wrap_add(ptr, k)]) begin
        winner  = wrap_add(ptr, k);
        any_val = 1'b1;
      end
    end
  end

  assign w_hs       = buf_valid && bus.w_rdy;
  assign can_accept = !buf_valid || w_hs;
  assign x_hs       = any_val && can_accept && !rst;

  always_comb begin
    bus.x_rdy = '0;
    if (x_hs) bus.x_rdy[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_q     <= '0;
      ptr       <= '0;
    end else if (x_hs) begin
      // A same-cycle drain is implied: can_accept already covered it.
      buf_valid     <= 1'b1;
      buf_q.pc      <= bus.x_pc[winner];
      buf_q.seq_num <= bus.x_seq_num[winner];
      buf_q.waddr   <= bus.x_waddr[winner];
      buf_q.wdata   <= bus.x_wdata[winner];
      buf_q.wen     <= bus.x_wen[winner];
      buf_q.src     <= winner;
      ptr           <= (winner == src_bits'(p_num_units - 1)) ? '0 : winner + 1'b1;
    end else if (w_hs) begin
      buf_valid <= 1'b0;
    end
  end

  assign bus.w_val     = buf_valid;
  assign bus.w_pc      = buf_q.pc;
  assign bus.w_seq_num = buf_q.seq_num;
  assign bus.w_waddr   = buf_q.waddr;
  assign bus.w_wdata   = buf_q.wdata;
  assign bus.w_wen     = buf_q.wen;
  assign bus.w_src     = buf_q.src;

  // One-character trace: granted unit digit, or a space when nothing is granted.
  function automatic logic [7:0] trace();
    return x_hs ? (8'h30 + 8'(winner)) : 8'h20;
  endfunction
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed checks on a 3-unit arbiter plus a randomized scoreboard run on a 4-unit instance.
module tb_writeback_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  writeback_arbiter_if #(.p_num_units(3), .p_seq_num_bits(5)) bus3();
  writeback_arbiter_if #(.p_num_units(4), .p_seq_num_bits(5)) bus4();

  writeback_arbiter #(.p_num_units(3), .p_seq_num_bits(5)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  writeback_arbiter #(.p_num_units(4), .p_seq_num_bits(5)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  src;
  } m_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus3.x_val = 3'b111;
    bus3.w_rdy = 1'b0;
    step();
    step();
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b000) begin
      fails++; $display("FAIL reset_xrdy_in_rst: got %b want 000", bus3.x_rdy);
    end
    bus3.x_val = 3'b000;
    rst = 1'b0;
    #1;
    tests++;
    if ({bus3.w_val, bus3.w_pc, bus3.w_seq_num, bus3.w_waddr, bus3.w_wdata, bus3.w_wen, bus3.w_src} !== 78'd0) begin
      fails++; $display("FAIL reset_outputs: w_val=%b pc=%h src=%0d want all zero", bus3.w_val, bus3.w_pc, bus3.w_src);
    end
    tests++;
    if (bus3.x_rdy !== 3'b000) begin
      fails++; $display("FAIL reset_xrdy_idle: got %b want 000", bus3.x_rdy);
    end
    bus3.x_val = 3'b110;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b010) begin
      fails++; $display("FAIL reset_first_winner: got %b want 010", bus3.x_rdy);
    end
    bus3.x_val = 3'b000;
    step();
    tests++;
    if (bus3.w_val !== 1'b0) begin
      fails++; $display("FAIL reset_no_msg: w_val got %b want 0", bus3.w_val);
    end
  endtask

  task automatic test_single();
    bus3.x_pc[1]      = 32'h200;
    bus3.x_seq_num[1] = 5'd3;
    bus3.x_waddr[1]   = 5'd5;
    bus3.x_wdata[1]   = 32'hDEADBEEF;
    bus3.x_wen[1]     = 1'b1;
    bus3.x_val        = 3'b010;
    bus3.w_rdy        = 1'b1;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b010) begin
      fails++; $display("FAIL single_grant: got %b want 010", bus3.x_rdy);
    end
    step();
    bus3.x_val = 3'b000;
    tests++;
    if ({bus3.w_val, bus3.w_pc, bus3.w_seq_num, bus3.w_waddr, bus3.w_wdata, bus3.w_wen, bus3.w_src} !==
        {1'b1, 32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1, 2'd1}) begin
      fails++; $display("FAIL single_msg: got val=%b pc=%h seq=%0d waddr=%0d wdata=%h wen=%b src=%0d want 1 200 3 5 deadbeef 1 1",
                        bus3.w_val, bus3.w_pc, bus3.w_seq_num, bus3.w_waddr, bus3.w_wdata, bus3.w_wen, bus3.w_src);
    end
    step();
    tests++;
    if (bus3.w_val !== 1'b0) begin
      fails++; $display("FAIL single_drain: w_val got %b want 0", bus3.w_val);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus3.x_pc[i]      = 32'h1000 + 32'(i);
      bus3.x_seq_num[i] = 5'(i);
      bus3.x_waddr[i]   = 5'(i + 1);
      bus3.x_wdata[i]   = 32'hA0 + 32'(i);
      bus3.x_wen[i]     = 1'b1;
    end
    bus3.x_val = 3'b111;
    bus3.w_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      e = 3'b001 << (c % 3);
      tests++;
      if (bus3.x_rdy !== e) begin
        fails++; $display("FAIL rr_onehot[%0d]: got %b want %b", c, bus3.x_rdy, e);
      end
      step();
      tests++;
      if ({bus3.w_val, bus3.w_src, bus3.w_seq_num, bus3.w_pc} !== {1'b1, 2'(c % 3), 5'(c % 3), 32'h1000 + 32'(c % 3)}) begin
        fails++; $display("FAIL rr_order[%0d]: got val=%b src=%0d seq=%0d pc=%h want src=%0d", c,
                          bus3.w_val, bus3.w_src, bus3.w_seq_num, bus3.w_pc, c % 3);
      end
    end
    bus3.x_val = 3'b000;
    step();
    tests++;
    if (bus3.w_val !== 1'b0) begin
      fails++; $display("FAIL rr_drain: w_val got %b want 0", bus3.w_val);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus3.x_val = 3'b101;
    bus3.w_rdy = 1'b1;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b001) begin
      fails++; $display("FAIL bp_first: got %b want 001", bus3.x_rdy);
    end
    step();
    bus3.w_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (bus3.x_rdy !== 3'b000) begin
        fails++; $display("FAIL bp_xrdy[%0d]: got %b want 000", c, bus3.x_rdy);
      end
      tests++;
      if ({bus3.w_val, bus3.w_src, bus3.w_pc} !== {1'b1, 2'd0, 32'h1000}) begin
        fails++; $display("FAIL bp_hold[%0d]: got val=%b src=%0d pc=%h want 1 0 1000", c, bus3.w_val, bus3.w_src, bus3.w_pc);
      end
      step();
    end
    bus3.w_rdy = 1'b1;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b100) begin
      fails++; $display("FAIL bp_release_grant: got %b want 100", bus3.x_rdy);
    end
    step();
    bus3.x_val = 3'b000;
    tests++;
    if ({bus3.w_val, bus3.w_src, bus3.w_pc} !== {1'b1, 2'd2, 32'h1002}) begin
      fails++; $display("FAIL bp_second: got val=%b src=%0d pc=%h want 1 2 1002", bus3.w_val, bus3.w_src, bus3.w_pc);
    end
    step();
  endtask

  task automatic test_wrap_skip();
    bus3.x_val = 3'b010;
    bus3.w_rdy = 1'b1;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b010) begin
      fails++; $display("FAIL wrap_skip_grant: got %b want 010", bus3.x_rdy);
    end
    step();
    tests++;
    if ({bus3.w_val, bus3.w_src} !== {1'b1, 2'd1}) begin
      fails++; $display("FAIL wrap_skip_src: got val=%b src=%0d want 1 1", bus3.w_val, bus3.w_src);
    end
    bus3.x_val = 3'b111;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b100) begin
      fails++; $display("FAIL wrap_ptr_after: got %b want 100", bus3.x_rdy);
    end
    bus3.x_val = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    bus3.x_val = 3'b100;
    bus3.w_rdy = 1'b0;
    step();
    bus3.x_val = 3'b000;
    tests++;
    if ({bus3.w_val, bus3.w_src} !== {1'b1, 2'd2}) begin
      fails++; $display("FAIL rstmid_loaded: got val=%b src=%0d want 1 2", bus3.w_val, bus3.w_src);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({bus3.w_val, bus3.w_pc, bus3.w_seq_num, bus3.w_waddr, bus3.w_wdata, bus3.w_wen, bus3.w_src} !== 78'd0) begin
      fails++; $display("FAIL rstmid_cleared: w_val=%b pc=%h src=%0d want all zero", bus3.w_val, bus3.w_pc, bus3.w_src);
    end
    bus3.w_rdy = 1'b1;
    step();
    tests++;
    if (bus3.w_val !== 1'b0) begin
      fails++; $display("FAIL rstmid_discard: w_val got %b want 0", bus3.w_val);
    end
    bus3.x_val = 3'b111;
    #1;
    tests++;
    if (bus3.x_rdy !== 3'b001) begin
      fails++; $display("FAIL rstmid_first_grant: got %b want 001", bus3.x_rdy);
    end
    step();
    bus3.x_val = 3'b000;
    tests++;
    if ({bus3.w_val, bus3.w_src, bus3.w_pc} !== {1'b1, 2'd0, 32'h1000}) begin
      fails++; $display("FAIL rstmid_post_msg: got val=%b src=%0d pc=%h want 1 0 1000", bus3.w_val, bus3.w_src, bus3.w_pc);
    end
    step();
  endtask

  task automatic test_stress();
    m_t         pend[4];
    m_t         exp_q[$];
    logic [3:0] vld;
    logic [3:0] exp_rdy;
    int         sent[4];
    int         waitc[4];
    int         maxwait;
    int         received;
    int         mptr;
    int         g;
    int         idx;
    int         cyc;
    const int   nmsg = 25;
    vld = '0; mptr = 0; maxwait = 0; received = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin sent[i] = 0; waitc[i] = 0; end
    do_reset();
    while (received < 4 * nmsg && cyc < 4000) begin
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (!vld[i] && sent[i] < nmsg && $urandom_range(1) == 1) begin
          pend[i].pc    = 32'h4000_0000 | (32'(i) << 16) | 32'(sent[i]);
          pend[i].seq   = 5'($urandom);
          pend[i].waddr = 5'($urandom);
          pend[i].wdata = $urandom;
          pend[i].wen   = 1'($urandom);
          pend[i].src   = 2'(i);
          vld[i] = 1'b1;
          sent[i]++;
        end
        bus4.x_pc[i]      = pend[i].pc;
        bus4.x_seq_num[i] = pend[i].seq;
        bus4.x_waddr[i]   = pend[i].waddr;
        bus4.x_wdata[i]   = pend[i].wdata;
        bus4.x_wen[i]     = pend[i].wen;
      end
      bus4.x_val = vld;
      bus4.w_rdy = 1'($urandom_range(1));
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (mptr + k) % 4;
        if (g < 0 && vld[idx]) g = idx;
      end
      exp_rdy = (g >= 0 && (exp_q.size() == 0 || bus4.w_rdy)) ? (4'b0001 << g) : 4'b0000;
      tests++;
      if (bus4.x_rdy !== exp_rdy) begin
        fails++; $display("FAIL stress_xrdy[%0d]: got %b want %b", cyc, bus4.x_rdy, exp_rdy);
      end
      tests++;
      if (bus4.w_val !== (exp_q.size() != 0)) begin
        fails++; $display("FAIL stress_wval[%0d]: got %b want %b", cyc, bus4.w_val, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        tests++;
        if ({bus4.w_pc, bus4.w_seq_num, bus4.w_waddr, bus4.w_wdata, bus4.w_wen, bus4.w_src} !== exp_q[0]) begin
          fails++; $display("FAIL stress_msg[%0d]: got pc=%h src=%0d want pc=%h src=%0d", cyc,
                            bus4.w_pc, bus4.w_src, exp_q[0].pc, exp_q[0].src);
        end
        if (bus4.w_rdy) begin
          void'(exp_q.pop_front());
          received++;
        end
      end
      if (exp_rdy != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (i == g) waitc[i] = 0;
          else if (vld[i]) begin
            waitc[i]++;
            if (waitc[i] > maxwait) maxwait = waitc[i];
          end
        end
        exp_q.push_back(pend[g]);
        vld[g] = 1'b0;
        mptr = (g + 1) % 4;
      end
      step();
    end
    bus4.x_val = 4'b0000;
    tests++;
    if (received != 4 * nmsg) begin
      fails++; $display("FAIL stress_complete: received %0d want %0d within cycle budget", received, 4 * nmsg);
    end
    tests++;
    if (maxwait > 3) begin
      fails++; $display("FAIL stress_fairness: max other-unit accepts while waiting %0d want <= 3", maxwait);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus3.x_val = '0; bus3.x_pc = '0; bus3.x_seq_num = '0; bus3.x_waddr = '0;
    bus3.x_wdata = '0; bus3.x_wen = '0; bus3.w_rdy = 1'b0;
    bus4.x_val = '0; bus4.x_pc = '0; bus4.x_seq_num = '0; bus4.x_waddr = '0;
    bus4.x_wdata = '0; bus4.x_wen = '0; bus4.w_rdy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    test_stress();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
